// File: rtl/uart_pkg.sv
// uart_pkg: shared UART word width, capture FSM states and the rx entry record.
package uart_pkg;
  localparam int UART_WIDTH = 32;
  typedef enum logic {CAP_IDLE = 1'b0, CAP_ACK = 1'b1} cap_state_t;
  typedef struct packed {
    logic [UART_WIDTH-1:0] data;
    logic perr;
    logic ferr;
  } rx_entry_t;
endpackage

// File: rtl/uart_fifo_mem.sv
// uart_fifo_mem: DEPTH x W storage, synchronous write, asynchronous read, no reset.
module uart_fifo_mem #(
  parameter int W = 34,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [W-1:0]             wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [W-1:0]             rdata
);
  logic [W-1:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: UART receive capture handshake feeding a first-word-fall-through FIFO.
// Define UART_RX_FIFO_DROP_ERR_EN to discard words flagged with parity or framing errors.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int WIDTH = UART_WIDTH,
  parameter int DEPTH = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [WIDTH-1:0]          rx_data,
  input  logic                      rx_ready,
  input  logic                      parity_error,
  input  logic                      framing_error,
  output logic                      rx_clear,
  output logic [WIDTH-1:0]          m_data,
  output logic                      m_perr,
  output logic                      m_ferr,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic [$clog2(DEPTH):0]    level,
  output logic                      full,
  output logic                      empty,
  output logic                      overflow,
  input  logic                      ovf_clear
);
  localparam int AW = $clog2(DEPTH);
  cap_state_t state;
  logic [AW-1:0] wptr, rptr;
  logic [WIDTH+1:0] rdata;
  logic push_req, keep, pop, push, ovf_set;
  assign push_req = state == CAP_IDLE && rx_ready;
`ifdef UART_RX_FIFO_DROP_ERR_EN
  assign keep = !(parity_error || framing_error);
`else
  assign keep = 1'b1;
`endif
  assign pop     = m_valid && m_ready;
  assign push    = push_req && keep && (!full || pop);
  assign ovf_set = push_req && keep && full && !pop;
  assign full    = level == (AW+1)'(DEPTH);
  assign empty   = level == '0;
  assign m_valid = !empty;
  assign {m_data, m_perr, m_ferr} = rdata;
  // rx_clear tracks the ACK state so the receiver sees a registered acknowledge
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state    <= CAP_IDLE;
      rx_clear <= 1'b0;
      wptr     <= '0;
      rptr     <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else begin
      if (state == CAP_IDLE && rx_ready) begin
        state    <= CAP_ACK;
        rx_clear <= 1'b1;
      end else if (state == CAP_ACK && !rx_ready) begin
        state    <= CAP_IDLE;
        rx_clear <= 1'b0;
      end
      wptr     <= wptr + AW'(push);
      rptr     <= rptr + AW'(pop);
      level    <= level + (AW+1)'(push) - (AW+1)'(pop);
      overflow <= ovf_set || (overflow && !ovf_clear);
    end
  uart_fifo_mem #(.W(WIDTH+2), .DEPTH(DEPTH)) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wptr),
    .wdata ({rx_data, parity_error, framing_error}),
    .raddr (rptr),
    .rdata (rdata)
  );
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed and random stimulus against a queue-based reference model.
module tb_uart_rx_fifo;
  localparam int WIDTH = 32;
  localparam int DEPTH = 16;
`ifdef UART_RX_FIFO_DROP_ERR_EN
  localparam bit DROP = 1'b1;
`else
  localparam bit DROP = 1'b0;
`endif
  logic clk = 1'b0, rst_n = 1'b0;
  logic [WIDTH-1:0] rx_data = '0;
  logic rx_ready = 1'b0, parity_error = 1'b0, framing_error = 1'b0;
  logic rx_clear, m_perr, m_ferr, m_valid, full, empty, overflow;
  logic m_ready = 1'b0, ovf_clear = 1'b0;
  logic [WIDTH-1:0] m_data;
  logic [$clog2(DEPTH):0] level;
  int total = 0, bad = 0;
  logic [WIDTH+1:0] q[$];
  bit mdl_ovf = 1'b0, mdl_ack = 1'b0;

  uart_rx_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_ready(rx_ready),
    .parity_error(parity_error), .framing_error(framing_error), .rx_clear(rx_clear),
    .m_data(m_data), .m_perr(m_perr), .m_ferr(m_ferr), .m_valid(m_valid),
    .m_ready(m_ready), .level(level), .full(full), .empty(empty),
    .overflow(overflow), .ovf_clear(ovf_clear)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("level", 64'(level), 64'(q.size()));
    chk("empty", 64'(empty), 64'(q.size() == 0));
    chk("full", 64'(full), 64'(q.size() == DEPTH));
    chk("m_valid", 64'(m_valid), 64'(q.size() != 0));
    chk("overflow", 64'(overflow), 64'(mdl_ovf));
    chk("rx_clear", 64'(rx_clear), 64'(mdl_ack));
    if (q.size() > 0) begin
      chk("m_data", 64'(m_data), 64'(q[0][WIDTH+1:2]));
      chk("m_perr", 64'(m_perr), 64'(q[0][1]));
      chk("m_ferr", 64'(m_ferr), 64'(q[0][0]));
    end
  endtask

  task automatic model_reset();
    q.delete();
    mdl_ovf = 1'b0;
    mdl_ack = 1'b0;
  endtask

  // One clock: rx_clear is rx_ready seen one edge later; a word is new when rx_ready is high and not yet acknowledged
  task automatic step();
    bit pop, preq, keep, room, rdy, clr;
    logic [WIDTH+1:0] word;
    pop  = q.size() > 0 && m_ready;
    preq = rx_ready && !mdl_ack;
    keep = !(DROP && (parity_error || framing_error));
    room = q.size() < DEPTH || pop;
    word = {rx_data, parity_error, framing_error};
    rdy  = rx_ready;
    clr  = ovf_clear;
    @(posedge clk);
    #1;
    if (!rst_n) model_reset();
    else begin
      if (pop) void'(q.pop_front());
      if (preq && keep && room) q.push_back(word);
      mdl_ovf = (preq && keep && !room) || (mdl_ovf && !clr);
      mdl_ack = rdy;
    end
    check_all();
  endtask

  task automatic push_word(input logic [WIDTH-1:0] d, input logic pe, input logic fe);
    rx_data = d; parity_error = pe; framing_error = fe; rx_ready = 1'b1;
    step();
    rx_ready = 1'b0; parity_error = 1'b0; framing_error = 1'b0;
    step();
  endtask

  task automatic drain(input int n);
    m_ready = 1'b1;
    repeat (n) step();
    m_ready = 1'b0;
  endtask

  initial begin
    repeat (2) step();
    chk("rst_level", 64'(level), 64'd0);
    chk("rst_empty", 64'(empty), 64'd1);
    rst_n = 1'b1;
    step();
    // single word
    rx_data = 32'hDEADBEEF; rx_ready = 1'b1;
    step();
    rx_ready = 1'b0;
    chk("sw_clear", 64'(rx_clear), 64'd1);
    chk("sw_data", 64'(m_data), 64'hDEADBEEF);
    chk("sw_level", 64'(level), 64'd1);
    step();
    drain(1);
    chk("sw_empty", 64'(empty), 64'd1);
    // fill, overflow, drain, clear
    for (int i = 0; i < DEPTH; i++) push_word(WIDTH'(i), 1'b0, 1'b0);
    chk("fill_full", 64'(full), 64'd1);
    chk("fill_level", 64'(level), 64'd16);
    push_word(32'd16, 1'b0, 1'b0);
    chk("fill_ovf", 64'(overflow), 64'd1);
    chk("fill_ovf_level", 64'(level), 64'd16);
    drain(DEPTH);
    ovf_clear = 1'b1;
    step();
    ovf_clear = 1'b0;
    chk("ovf_cleared", 64'(overflow), 64'd0);
    // full with simultaneous push and pop
    for (int i = 0; i < DEPTH; i++) push_word(WIDTH'(100 + i), 1'b0, 1'b0);
    rx_data = 32'h55; rx_ready = 1'b1; m_ready = 1'b1;
    step();
    rx_ready = 1'b0; m_ready = 1'b0;
    chk("sim_level", 64'(level), 64'd16);
    chk("sim_head", 64'(m_data), 64'd101);
    chk("sim_ovf", 64'(overflow), 64'd0);
    step();
    drain(DEPTH - 1);
    chk("sim_last", 64'(m_data), 64'h55);
    drain(1);
    // level-style rx_ready
    rx_data = 32'h7; rx_ready = 1'b1;
    repeat (5) begin
      step();
      chk("lvl_clear", 64'(rx_clear), 64'd1);
    end
    rx_ready = 1'b0;
    step();
    chk("lvl_once", 64'(level), 64'd1);
    chk("lvl_clear_low", 64'(rx_clear), 64'd0);
    drain(1);
    // errored word
    rx_data = 32'h12345678; parity_error = 1'b1; rx_ready = 1'b1;
    step();
    chk("err_level", 64'(level), DROP ? 64'd0 : 64'd1);
    chk("err_clear", 64'(rx_clear), 64'd1);
    chk("err_perr", 64'(m_perr && m_valid), 64'(!DROP));
    parity_error = 1'b0; rx_ready = 1'b0;
    step();
    drain(1);
    // random traffic
    for (int c = 0; c < 3000; c++) begin
      rx_ready      = $urandom_range(0, 2) != 0;
      rx_data       = $urandom;
      parity_error  = $urandom_range(0, 3) == 0;
      framing_error = $urandom_range(0, 3) == 0;
      m_ready       = $urandom_range(0, 9) < (c < 1500 ? 1 : 7);
      ovf_clear     = $urandom_range(0, 15) == 0;
      step();
    end
    rx_ready = 1'b0; parity_error = 1'b0; framing_error = 1'b0; ovf_clear = 1'b1;
    drain(DEPTH + 2);
    ovf_clear = 1'b0;
    // asynchronous reset with 3 entries and ACK pending
    push_word(32'hA1, 1'b0, 1'b0);
    push_word(32'hA2, 1'b0, 1'b0);
    rx_data = 32'hA3; rx_ready = 1'b1;
    step();
    chk("pre_rst_level", 64'(level), 64'd3);
    #3 rst_n = 1'b0;
    #1;
    model_reset();
    chk("arst_level", 64'(level), 64'd0);
    chk("arst_valid", 64'(m_valid), 64'd0);
    chk("arst_clear", 64'(rx_clear), 64'd0);
    step();
    rst_n = 1'b1; rx_data = 32'hABC;
    step();
    chk("post_rst_cap", 64'(level), 64'd1);
    rx_ready = 1'b0;
    step();
    drain(1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
